// File: rtl/qpp_pkg.sv
// Shared constants and FSM state type for the QPP interleaver address generator.
package qpp_pkg;

    localparam int DATA_WIDTH  = 9;
    localparam int COUNT_WIDTH = 13;
    localparam int MAX_VALUE   = 20;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

endpackage

// File: rtl/qpp_mod_add.sv
// Combinational modular adder: (a + b) mod m, valid when both operands are below m.
// One extra bit of sum headroom keeps a + b < 2m exact, so a single
// conditional subtract completes the reduction.
module qpp_mod_add #(
    parameter int WIDTH = qpp_pkg::COUNT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] sum_mod
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = sum - {1'b0, m};

    // Subtract the modulus once when the raw sum reaches or exceeds it
    always_comb begin
        sum_mod = sum[WIDTH-1:0];
        if (sum >= {1'b0, m}) begin
            sum_mod = diff[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/qpp_interleaver.sv
// LTE turbo-code QPP interleaver address generator.
// Streams pi(i) = (f1*i + f2*i^2) mod K for i = 0..K-1, one index per clock.
// The quadratic is evaluated by second-order differences, so only modular
// adds are needed: pi(i+1) = pi(i) + g(i), g(i+1) = g(i) + 2*f2, g(0) = f1 + f2.
module qpp_interleaver #(
    parameter int DATA_WIDTH  = qpp_pkg::DATA_WIDTH,
    parameter int COUNT_WIDTH = qpp_pkg::COUNT_WIDTH,
    parameter int MAX_VALUE   = qpp_pkg::MAX_VALUE
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_in,
    input  logic [DATA_WIDTH:0]    f1,
    input  logic [DATA_WIDTH:0]    f2,
    input  logic [COUNT_WIDTH-1:0] K,
    output logic [MAX_VALUE-1:0]   index_out,
    output logic                   index_valid_out
);

    import qpp_pkg::*;

    state_t                 state;
    logic [COUNT_WIDTH-1:0] k_reg;
    logic [COUNT_WIDTH-1:0] d_reg;
    logic [COUNT_WIDTH-1:0] pi_reg;
    logic [COUNT_WIDTH-1:0] g_reg;
    logic [COUNT_WIDTH-1:0] i_reg;

    logic [COUNT_WIDTH-1:0] f1_ext;
    logic [COUNT_WIDTH-1:0] f2_ext;
    logic [COUNT_WIDTH-1:0] g0_next;
    logic [COUNT_WIDTH-1:0] d_next;
    logic [COUNT_WIDTH-1:0] pi_next;
    logic [COUNT_WIDTH-1:0] g_next;
    logic                   last_index;

    assign f1_ext     = COUNT_WIDTH'(f1);
    assign f2_ext     = COUNT_WIDTH'(f2);
    assign last_index = (i_reg == k_reg - COUNT_WIDTH'(1));

    // Start-of-block terms come straight from the ports, before K is latched
    qpp_mod_add #(.WIDTH(COUNT_WIDTH)) u_g0_add (
        .a       (f1_ext),
        .b       (f2_ext),
        .m       (K),
        .sum_mod (g0_next)
    );

    qpp_mod_add #(.WIDTH(COUNT_WIDTH)) u_d_add (
        .a       (f2_ext),
        .b       (f2_ext),
        .m       (K),
        .sum_mod (d_next)
    );

    // Per-index recursion runs against the latched block size
    qpp_mod_add #(.WIDTH(COUNT_WIDTH)) u_pi_add (
        .a       (pi_reg),
        .b       (g_reg),
        .m       (k_reg),
        .sum_mod (pi_next)
    );

    qpp_mod_add #(.WIDTH(COUNT_WIDTH)) u_g_add (
        .a       (g_reg),
        .b       (d_reg),
        .m       (k_reg),
        .sum_mod (g_next)
    );

    // Block FSM: latch parameters on a start strobe, then emit K registered indices
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            k_reg           <= '0;
            d_reg           <= '0;
            pi_reg          <= '0;
            g_reg           <= '0;
            i_reg           <= '0;
            index_out       <= '0;
            index_valid_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    index_out       <= '0;
                    index_valid_out <= 1'b0;
                    if (valid_in && (K != '0)) begin
                        k_reg  <= K;
                        d_reg  <= d_next;
                        g_reg  <= g0_next;
                        pi_reg <= '0;
                        i_reg  <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    index_out       <= MAX_VALUE'(pi_reg);
                    index_valid_out <= 1'b1;
                    pi_reg          <= pi_next;
                    g_reg           <= g_next;
                    i_reg           <= i_reg + COUNT_WIDTH'(1);
                    if (last_index) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qpp_interleaver.sv
// Self-checking bench for qpp_interleaver: expected indices are queued from a
// direct (f1*i + f2*i*i) % K model at start time and popped as valids appear.
module tb_qpp_interleaver;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [9:0]  f1;
    logic [9:0]  f2;
    logic [12:0] K;
    logic [19:0] index_out;
    logic        index_valid_out;

    int checks   = 0;
    int failures = 0;

    logic [19:0] sb[$];
    logic [19:0] got_q[$];

    qpp_interleaver dut (
        .clk             (clk),
        .rst             (rst),
        .valid_in        (valid_in),
        .f1              (f1),
        .f2              (f2),
        .K               (K),
        .index_out       (index_out),
        .index_valid_out (index_valid_out)
    );

    // Free-running 100 MHz clock
    always #5 clk = ~clk;

    // Hard stop in case a bounded loop is somehow bypassed
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time exceeded, required completion before 2 ms");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [19:0] golden(input int a, input int b, input int k, input int i);
        longint t;
        t = (longint'(a) * longint'(i) + longint'(b) * longint'(i) * longint'(i)) % longint'(k);
        return 20'(t);
    endfunction

    // Queue the expected block, pulse valid_in for one cycle, then scramble the inputs
    task automatic start_block(input int a, input int b, input int k);
        for (int i = 0; i < k; i++) sb.push_back(golden(a, b, k, i));
        f1       = 10'(a);
        f2       = 10'(b);
        K        = 13'(k);
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        f1       = 10'($urandom);
        f2       = 10'($urandom);
        K        = 13'($urandom);
    endtask

    // One complete block: values, latency/contiguity, permutation, idle tail
    task automatic test_sequence(input int a, input int b, input int k, input string name);
        int          got = 0;
        int          cyc = 0;
        int          dup = 0;
        bit          seen[int];
        logic [19:0] exp;
        got_q.delete();
        start_block(a, b, k);
        while (got < k && cyc < k + 16) begin
            @(negedge clk);
            cyc++;
            if (index_valid_out) begin
                exp = (sb.size() > 0) ? sb.pop_front() : 20'hFFFFF;
                got_q.push_back(index_out);
                checks++;
                if (index_out !== exp) begin
                    failures++;
                    $display("[TB] FAIL %s_value i=%0d: got %0d, expected %0d", name, got, index_out, exp);
                end
                if (seen.exists(int'(index_out))) dup++;
                seen[int'(index_out)] = 1'b1;
                got++;
            end
        end
        checks++;
        if (got != k || cyc != k) begin
            failures++;
            $display("[TB] FAIL %s_stream: %0d valids over %0d cycles, expected %0d over %0d", name, got, cyc, k, k);
        end
        checks++;
        if (dup != 0 || seen.num() != k) begin
            failures++;
            $display("[TB] FAIL %s_permutation: %0d distinct, %0d repeats, expected %0d distinct, 0 repeats", name, seen.num(), dup, k);
        end
        @(negedge clk);
        checks++;
        if (index_valid_out !== 1'b0 || index_out !== 20'd0) begin
            failures++;
            $display("[TB] FAIL %s_tail: valid=%b index=%0d, expected valid=0 index=0", name, index_valid_out, index_out);
        end
        sb.delete();
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        valid_in = 1'b0;
        f1       = '0;
        f2       = '0;
        K        = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (index_valid_out !== 1'b0 || index_out !== 20'd0) begin
            failures++;
            $display("[TB] FAIL reset_state: valid=%b index=%0d, expected valid=0 index=0", index_valid_out, index_out);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (index_valid_out !== 1'b0 || index_out !== 20'd0) begin
            failures++;
            $display("[TB] FAIL idle_after_reset: valid=%b index=%0d, expected valid=0 index=0", index_valid_out, index_out);
        end
    endtask

    task automatic test_k40();
        logic [19:0] want[4];
        want = '{20'd0, 20'd13, 20'd6, 20'd19};
        test_sequence(3, 10, 40, "k40");
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (j >= got_q.size() || got_q[j] !== want[j]) begin
                failures++;
                $display("[TB] FAIL k40_known pi(%0d): got %0d, expected %0d", j, (j < got_q.size()) ? got_q[j] : 20'hFFFFF, want[j]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] want[3];
        want = '{20'd0, 20'd141, 20'd42};
        test_sequence(3, 10, 40, "b2b_first");
        #1000;
        @(negedge clk);
        test_sequence(21, 120, 160, "b2b_second");
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (j >= got_q.size() || got_q[j] !== want[j]) begin
                failures++;
                $display("[TB] FAIL k160_known pi(%0d): got %0d, expected %0d", j, (j < got_q.size()) ? got_q[j] : 20'hFFFFF, want[j]);
            end
        end
    endtask

    task automatic test_large_blocks();
        int          fa[3];
        int          fb[3];
        int          kk[3];
        logic [19:0] p1[3];
        fa = '{185, 71, 47};
        fb = '{124, 444, 186};
        kk = '{1984, 4736, 5952};
        p1 = '{20'd309, 20'd515, 20'd233};
        for (int n = 0; n < 3; n++) begin
            test_sequence(fa[n], fb[n], kk[n], $sformatf("k%0d", kk[n]));
            checks++;
            if (got_q.size() < 2 || got_q[1] !== p1[n]) begin
                failures++;
                $display("[TB] FAIL k%0d_pi1: got %0d, expected %0d", kk[n], (got_q.size() > 1) ? got_q[1] : 20'hFFFFF, p1[n]);
            end
        end
    endtask

    // A second start strobe with different parameters lands mid-block
    task automatic test_valid_ignored();
        int          got = 0;
        int          cyc = 0;
        int          extra = 0;
        logic [19:0] exp;
        start_block(3, 10, 40);
        while (got < 40 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (cyc == 10) begin
                valid_in = 1'b1;
                f1       = 10'd21;
                f2       = 10'd120;
                K        = 13'd160;
            end else begin
                valid_in = 1'b0;
            end
            if (index_valid_out) begin
                exp = (sb.size() > 0) ? sb.pop_front() : 20'hFFFFF;
                checks++;
                if (index_out !== exp) begin
                    failures++;
                    $display("[TB] FAIL ignored_value i=%0d: got %0d, expected %0d", got, index_out, exp);
                end
                got++;
            end
        end
        valid_in = 1'b0;
        checks++;
        if (got != 40 || cyc != 40) begin
            failures++;
            $display("[TB] FAIL ignored_stream: %0d valids over %0d cycles, expected 40 over 40", got, cyc);
        end
        repeat (8) begin
            @(negedge clk);
            if (index_valid_out) extra++;
        end
        checks++;
        if (extra != 0) begin
            failures++;
            $display("[TB] FAIL ignored_no_restart: %0d extra valids, expected 0", extra);
        end
        sb.delete();
    endtask

    // Next block is requested in the very cycle the last index is shown
    task automatic test_back_to_back_tight();
        int          got = 0;
        int          cyc = 0;
        logic [19:0] exp;
        start_block(3, 10, 40);
        while (got < 200 && cyc < 260) begin
            @(negedge clk);
            cyc++;
            if (index_valid_out) begin
                exp = (sb.size() > 0) ? sb.pop_front() : 20'hFFFFF;
                checks++;
                if (index_out !== exp) begin
                    failures++;
                    $display("[TB] FAIL tight_value n=%0d: got %0d, expected %0d", got, index_out, exp);
                end
                got++;
                if (got == 40) begin
                    start_block(21, 120, 160);
                    checks++;
                    if (index_valid_out !== 1'b0) begin
                        failures++;
                        $display("[TB] FAIL tight_gap: valid=%b, expected 0", index_valid_out);
                    end
                end
            end
        end
        checks++;
        if (got != 200 || cyc != 200) begin
            failures++;
            $display("[TB] FAIL tight_stream: %0d valids over %0d cycles, expected 200 over 200", got, cyc);
        end
        sb.delete();
        @(negedge clk);
    endtask

    task automatic test_k_zero();
        int cnt = 0;
        valid_in = 1'b1;
        f1       = 10'd3;
        f2       = 10'd10;
        K        = 13'd0;
        @(negedge clk);
        valid_in = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (index_valid_out) cnt++;
        end
        checks++;
        if (cnt != 0) begin
            failures++;
            $display("[TB] FAIL k_zero: %0d valids, expected 0", cnt);
        end
    endtask

    task automatic test_reset_mid_block();
        int          got = 0;
        int          cyc = 0;
        int          cnt = 0;
        logic [19:0] exp;
        start_block(21, 120, 160);
        while (got < 30 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (index_valid_out) begin
                exp = (sb.size() > 0) ? sb.pop_front() : 20'hFFFFF;
                checks++;
                if (index_out !== exp) begin
                    failures++;
                    $display("[TB] FAIL abort_value i=%0d: got %0d, expected %0d", got, index_out, exp);
                end
                got++;
            end
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (index_valid_out !== 1'b0 || index_out !== 20'd0) begin
            failures++;
            $display("[TB] FAIL async_abort: valid=%b index=%0d, expected valid=0 index=0", index_valid_out, index_out);
        end
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (index_valid_out) cnt++;
        end
        checks++;
        if (cnt != 0) begin
            failures++;
            $display("[TB] FAIL abort_no_resume: %0d valids, expected 0", cnt);
        end
        test_sequence(3, 10, 40, "post_reset");
        checks++;
        if (got_q.size() < 2 || got_q[0] !== 20'd0 || got_q[1] !== 20'd13) begin
            failures++;
            $display("[TB] FAIL post_reset_start: pi(0),pi(1) = %0d,%0d, expected 0,13",
                     (got_q.size() > 0) ? got_q[0] : 20'hFFFFF, (got_q.size() > 1) ? got_q[1] : 20'hFFFFF);
        end
    endtask

    initial begin
        test_reset();
        test_k40();
        test_back_to_back();
        test_large_blocks();
        test_valid_ignored();
        test_back_to_back_tight();
        test_k_zero();
        test_reset_mid_block();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
